// File: rtl/stream_patch_ctrl.sv
// rtl/stream_patch_ctrl.sv - raster sequencer feeding stream_patch with pixel, blanking and flush slots
// Define STREAM_PATCH_CTRL_STATS_EN to add the saturating stall_cnt output.
module stream_patch_ctrl #(
  parameter int BIT_WIDTH    = 8,
  parameter int IMAGE_HEIGHT = 480,
  parameter int IMAGE_WIDTH  = 640,
  parameter int FRAME_HEIGHT = 525,
  parameter int FRAME_WIDTH  = 800,
  parameter int PATCH_HEIGHT = 3,
  parameter int PATCH_WIDTH  = 3,
  parameter int CENTER_V     = PATCH_HEIGHT / 2,
  parameter int CENTER_H     = PATCH_WIDTH / 2,
  parameter int LEVEL        = 0,
  parameter int FLUSH_LEN    = ((PATCH_HEIGHT-1-CENTER_V)*FRAME_WIDTH + (PATCH_WIDTH-1-CENTER_H) + 1) * (1 << LEVEL),
  localparam int V_BITW      = 9,
  localparam int H_BITW      = 10
) (
  input  logic                 clock,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 stop,
  input  logic [7:0]           in_frames,
  input  logic                 src_valid,
  input  logic [BIT_WIDTH-1:0] src_pixel,
  output logic                 src_ready,
  input  logic                 dst_ready,
  output logic [BIT_WIDTH-1:0] pat_pixel,
  output logic [V_BITW-1:0]    pat_vcnt,
  output logic [H_BITW-1:0]    pat_hcnt,
  output logic                 pat_enable,
  output logic                 busy,
  output logic                 frame_start,
  output logic                 done
`ifdef STREAM_PATCH_CTRL_STATS_EN
  ,
  output logic [15:0]          stall_cnt
`endif
);

  // Raster counters are sized for the full frame; the ports carry the low bits, which are exact on active lines.
  localparam int VC_W = ($clog2(FRAME_HEIGHT) > V_BITW) ? $clog2(FRAME_HEIGHT) : V_BITW;
  localparam int HC_W = ($clog2(FRAME_WIDTH) > H_BITW) ? $clog2(FRAME_WIDTH) : H_BITW;
  localparam int FL_W = $clog2(FLUSH_LEN + 1);

  localparam logic [VC_W-1:0] V_ACT   = VC_W'(IMAGE_HEIGHT);
  localparam logic [VC_W-1:0] V_LAST  = VC_W'(FRAME_HEIGHT - 1);
  localparam logic [HC_W-1:0] H_ACT   = HC_W'(IMAGE_WIDTH);
  localparam logic [HC_W-1:0] H_LAST  = HC_W'(FRAME_WIDTH - 1);
  localparam logic [FL_W-1:0] FL_LAST = FL_W'(FLUSH_LEN);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  state_t          state, state_nx;
  logic [VC_W-1:0] v, v_nx;
  logic [HC_W-1:0] h, h_nx;
  logic [7:0]      frames_left, frames_left_nx;
  logic            finite, finite_nx;
  logic            stop_pend, stop_pend_nx;
  logic [FL_W-1:0] flush_cnt, flush_cnt_nx;
  logic            done_nx;
  logic            active, fire, line_end, frame_end, flush_last;

  assign active     = (v < V_ACT) && (h < H_ACT);
  assign line_end   = (h == H_LAST);
  assign frame_end  = line_end && (v == V_LAST);
  assign flush_last = (flush_cnt == FL_LAST);
  assign src_ready  = (state == RUN) && active && dst_ready;
  assign busy       = (state != IDLE);

  // Once all flush slots are out, FLUSH spends one idle cycle raising done.
  always_comb begin
    fire = 1'b0;
    case (state)
      RUN:     fire = dst_ready && (!active || src_valid);
      FLUSH:   fire = dst_ready && !flush_last;
      default: fire = 1'b0;
    endcase
  end

  always_comb begin
    state_nx       = state;
    v_nx           = v;
    h_nx           = h;
    frames_left_nx = frames_left;
    finite_nx      = finite;
    stop_pend_nx   = stop_pend;
    flush_cnt_nx   = flush_cnt;
    done_nx        = 1'b0;

    if (fire) begin
      if (line_end) begin
        h_nx = '0;
        v_nx = (v == V_LAST) ? '0 : v + 1'b1;
      end else begin
        h_nx = h + 1'b1;
      end
    end

    case (state)
      IDLE: begin
        if (start) begin
          state_nx       = RUN;
          frames_left_nx = in_frames;
          finite_nx      = (in_frames != 8'd0);
          stop_pend_nx   = 1'b0;
          v_nx           = '0;
          h_nx           = '0;
        end
      end
      RUN: begin
        if (stop) stop_pend_nx = 1'b1;
        if (fire && frame_end) begin
          if (finite) frames_left_nx = frames_left - 1'b1;
          if ((finite && frames_left == 8'd1) || stop_pend) begin
            state_nx     = FLUSH;
            flush_cnt_nx = '0;
          end
        end
      end
      FLUSH: begin
        if (fire) flush_cnt_nx = flush_cnt + 1'b1;
        if (flush_last) begin
          state_nx = IDLE;
          done_nx  = 1'b1;
          v_nx     = '0;
          h_nx     = '0;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      state       <= IDLE;
      v           <= '0;
      h           <= '0;
      frames_left <= '0;
      finite      <= 1'b0;
      stop_pend   <= 1'b0;
      flush_cnt   <= '0;
      done        <= 1'b0;
    end else begin
      state       <= state_nx;
      v           <= v_nx;
      h           <= h_nx;
      frames_left <= frames_left_nx;
      finite      <= finite_nx;
      stop_pend   <= stop_pend_nx;
      flush_cnt   <= flush_cnt_nx;
      done        <= done_nx;
    end
  end

  // Slot outputs hold their last value across stalls; only pat_enable marks a new slot.
  always_ff @(posedge clock) begin
    if (rst) begin
      pat_enable  <= 1'b0;
      pat_pixel   <= '0;
      pat_vcnt    <= '0;
      pat_hcnt    <= '0;
      frame_start <= 1'b0;
    end else begin
      pat_enable  <= fire;
      frame_start <= fire && (state == RUN) && (v == '0) && (h == '0);
      if (fire) begin
        pat_pixel <= ((state == RUN) && active) ? src_pixel : '0;
        pat_vcnt  <= v[V_BITW-1:0];
        pat_hcnt  <= h[H_BITW-1:0];
      end
    end
  end

`ifdef STREAM_PATCH_CTRL_STATS_EN
  always_ff @(posedge clock) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if ((state == IDLE) && start) begin
      stall_cnt <= '0;
    end else if (((state == RUN) || ((state == FLUSH) && !flush_last)) && !fire
                 && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_stream_patch_ctrl.sv
// tb/tb_stream_patch_ctrl.sv - scoreboard bench for stream_patch_ctrl on a 3x4 image in a 4x6 frame
module tb_stream_patch_ctrl;

  typedef struct {
    logic [8:0] v;
    logic [9:0] h;
    logic [7:0] px;
    logic       fs;
  } slot_t;

  logic       clock, rst, start, stop, src_valid, src_ready, dst_ready;
  logic [7:0] in_frames, src_pixel, pat_pixel;
  logic [8:0] pat_vcnt;
  logic [9:0] pat_hcnt;
  logic       pat_enable, busy, frame_start, done;
`ifdef STREAM_PATCH_CTRL_STATS_EN
  logic [15:0] stall_cnt;
`endif

  slot_t      sb[$];
  int         vectors, errors;
  logic [7:0] px_next;
  logic       sr_seen;
  int         accepted, first_en, last_en, en_cnt, sr_cnt, done_k, done_cnt, fs_cnt;

  stream_patch_ctrl #(
    .BIT_WIDTH(8), .IMAGE_HEIGHT(3), .IMAGE_WIDTH(4), .FRAME_HEIGHT(4), .FRAME_WIDTH(6),
    .PATCH_HEIGHT(3), .PATCH_WIDTH(3), .LEVEL(0)
  ) dut (
    .clock(clock), .rst(rst), .start(start), .stop(stop), .in_frames(in_frames),
    .src_valid(src_valid), .src_pixel(src_pixel), .src_ready(src_ready), .dst_ready(dst_ready),
    .pat_pixel(pat_pixel), .pat_vcnt(pat_vcnt), .pat_hcnt(pat_hcnt), .pat_enable(pat_enable),
    .busy(busy), .frame_start(frame_start), .done(done)
`ifdef STREAM_PATCH_CTRL_STATS_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) begin
    slot_t e;
    #1;
    if (!rst && pat_enable === 1'b1) begin
      vectors++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_slot: got v=%0d h=%0d px=%0h, want no output", pat_vcnt, pat_hcnt, pat_pixel);
      end else begin
        e = sb.pop_front();
        if ({pat_vcnt, pat_hcnt, pat_pixel, frame_start} !== {e.v, e.h, e.px, e.fs}) begin
          errors++;
          $display("FAIL slot: got v=%0d h=%0d px=%0h fs=%0b, want v=%0d h=%0d px=%0h fs=%0b",
                   pat_vcnt, pat_hcnt, pat_pixel, frame_start, e.v, e.h, e.px, e.fs);
        end
      end
    end
  end

  task automatic drive(input logic rs, input logic st, input logic sp, input logic sv, input logic dr);
    @(negedge clock);
    rst = rs; start = st; stop = sp; src_valid = sv; dst_ready = dr; src_pixel = px_next;
    #1;
    sr_seen = src_ready;
    if (sv && src_ready && !rs) begin
      px_next = px_next + 8'd37;
      accepted++;
    end
  endtask

  task automatic sample(input int k);
    if (pat_enable) begin
      if (first_en < 0) first_en = k;
      last_en = k;
      en_cnt++;
    end
    if (sr_seen) sr_cnt++;
    if (done) begin
      done_cnt++;
      if (done_k < 0) done_k = k;
    end
    if (frame_start) fs_cnt++;
  endtask

  task automatic push_run(input int nframes, input logic [7:0] base);
    slot_t      e;
    logic [7:0] px;
    px = base;
    for (int f = 0; f < nframes; f++)
      for (int vv = 0; vv < 4; vv++)
        for (int hh = 0; hh < 6; hh++) begin
          e.v  = 9'(vv);
          e.h  = 10'(hh);
          e.fs = (vv == 0 && hh == 0);
          if (vv < 3 && hh < 4) begin
            e.px = px;
            px   = px + 8'd37;
          end else begin
            e.px = 8'd0;
          end
          sb.push_back(e);
        end
    for (int i = 0; i < 8; i++) begin
      e.v = 9'(i / 6); e.h = 10'(i % 6); e.px = 8'd0; e.fs = 1'b0;
      sb.push_back(e);
    end
  endtask

  task automatic begin_run(input logic [7:0] frames, input int nframes, input logic with_stop);
    first_en = -1; last_en = -1; en_cnt = 0; sr_cnt = 0; done_k = -1; done_cnt = 0; fs_cnt = 0; accepted = 0;
    push_run(nframes, px_next);
    in_frames = frames;
    drive(1'b0, 1'b1, with_stop, 1'b1, 1'b1);
  endtask

  task automatic test_reset();
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b, want 0", busy); end
    vectors++; if (pat_enable !== 1'b0) begin errors++; $display("FAIL reset_enable: got %0b, want 0", pat_enable); end
    vectors++; if ({pat_vcnt, pat_hcnt, pat_pixel} !== 27'd0) begin errors++; $display("FAIL reset_slot: got v=%0d h=%0d px=%0h, want 0", pat_vcnt, pat_hcnt, pat_pixel); end
    vectors++; if ({frame_start, done, sr_seen} !== 3'b000) begin errors++; $display("FAIL reset_flags: got fs/done/ready=%b, want 000", {frame_start, done, sr_seen}); end
`ifdef STREAM_PATCH_CTRL_STATS_EN
    vectors++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL reset_stall_cnt: got %0d, want 0", stall_cnt); end
`endif
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_basic();
    begin_run(8'd1, 1, 1'b0);
    for (int k = 1; k <= 80; k++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      sample(k);
      if (done_k >= 0 && k > done_k) break;
    end
    vectors++; if (first_en !== 2) begin errors++; $display("FAIL basic_first_enable: got %0d, want 2", first_en); end
    vectors++; if (en_cnt !== 32 || last_en !== 33) begin errors++; $display("FAIL basic_enable_run: got %0d ending %0d, want 32 ending 33", en_cnt, last_en); end
    vectors++; if (sr_cnt !== 12) begin errors++; $display("FAIL basic_src_ready: got %0d, want 12", sr_cnt); end
    vectors++; if (done_k !== 34 || done_cnt !== 1) begin errors++; $display("FAIL basic_done: got cycle %0d count %0d, want 34 / 1", done_k, done_cnt); end
    vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_after: got %0b, want 0", busy); end
    vectors++; if (fs_cnt !== 1 || sb.size() !== 0) begin errors++; $display("FAIL basic_frames: got fs=%0d left=%0d, want 1 / 0", fs_cnt, sb.size()); end
  endtask

  task automatic test_src_stall();
    begin_run(8'd1, 1, 1'b0);
    for (int k = 1; k <= 80; k++) begin
      drive(1'b0, 1'b0, 1'b0, !(k >= 9 && k <= 11), 1'b1);
      sample(k);
      if (k >= 10 && k <= 12) begin
        vectors++;
        if ({pat_enable, pat_vcnt, pat_hcnt} !== {1'b0, 9'd1, 10'd1}) begin
          errors++; $display("FAIL src_stall_hold: got en=%0b v=%0d h=%0d, want en=0 v=1 h=1", pat_enable, pat_vcnt, pat_hcnt);
        end
      end
      if (done_k >= 0 && k > done_k) break;
    end
    vectors++; if (en_cnt !== 32 || last_en - first_en !== 34) begin errors++; $display("FAIL src_stall_span: got %0d over %0d, want 32 over 34", en_cnt, last_en - first_en); end
    vectors++; if (accepted !== 12 || sb.size() !== 0) begin errors++; $display("FAIL src_stall_pixels: got %0d left=%0d, want 12 / 0", accepted, sb.size()); end
  endtask

  task automatic test_blank_invalid();
    int idx;
    logic sv;
    begin_run(8'd1, 1, 1'b0);
    for (int k = 1; k <= 80; k++) begin
      idx = k - 1;
      sv  = (idx < 24) && (idx / 6 < 3) && (idx % 6 < 4);
      drive(1'b0, 1'b0, 1'b0, sv, 1'b1);
      sample(k);
      if (done_k >= 0 && k > done_k) break;
    end
    vectors++; if (en_cnt !== 32 || last_en !== 33) begin errors++; $display("FAIL blank_enable_run: got %0d ending %0d, want 32 ending 33", en_cnt, last_en); end
    vectors++; if (accepted !== 12 || sb.size() !== 0) begin errors++; $display("FAIL blank_pixels: got %0d left=%0d, want 12 / 0", accepted, sb.size()); end
  endtask

  task automatic test_dst_stall();
    logic [7:0] held_px;
    held_px = px_next + 8'd9 * 8'd37;
    begin_run(8'd1, 1, 1'b0);
    for (int k = 1; k <= 80; k++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b1, !(k >= 15 && k <= 19));
      sample(k);
      if (k >= 15 && k <= 19) begin
        vectors++; if (sr_seen !== 1'b0) begin errors++; $display("FAIL dst_stall_ready: got %0b, want 0", sr_seen); end
      end
      if (k >= 16 && k <= 20) begin
        vectors++;
        if ({pat_enable, pat_vcnt, pat_hcnt, pat_pixel} !== {1'b0, 9'd2, 10'd1, held_px}) begin
          errors++; $display("FAIL dst_stall_hold: got en=%0b v=%0d h=%0d px=%0h, want en=0 v=2 h=1 px=%0h", pat_enable, pat_vcnt, pat_hcnt, pat_pixel, held_px);
        end
      end
      if (done_k >= 0 && k > done_k) break;
    end
    vectors++; if (en_cnt !== 32 || last_en !== 38) begin errors++; $display("FAIL dst_stall_span: got %0d ending %0d, want 32 ending 38", en_cnt, last_en); end
    vectors++; if (accepted !== 12 || sb.size() !== 0) begin errors++; $display("FAIL dst_stall_pixels: got %0d left=%0d, want 12 / 0", accepted, sb.size()); end
`ifdef STREAM_PATCH_CTRL_STATS_EN
    vectors++; if (stall_cnt !== 16'd5) begin errors++; $display("FAIL dst_stall_cnt: got %0d, want 5", stall_cnt); end
`endif
  endtask

  task automatic test_stop();
    begin_run(8'd0, 2, 1'b1);
    for (int k = 1; k <= 150; k++) begin
      drive(1'b0, k == 10, k == 30, 1'b1, 1'b1);
      sample(k);
      if (done_k >= 0 && k > done_k) break;
    end
    vectors++; if (en_cnt !== 56 || last_en !== 57) begin errors++; $display("FAIL stop_enable_run: got %0d ending %0d, want 56 ending 57", en_cnt, last_en); end
    vectors++; if (fs_cnt !== 2) begin errors++; $display("FAIL stop_frame_starts: got %0d, want 2", fs_cnt); end
    vectors++; if (done_k !== 58 || done_cnt !== 1) begin errors++; $display("FAIL stop_done: got cycle %0d count %0d, want 58 / 1", done_k, done_cnt); end
    vectors++; if (accepted !== 24 || sb.size() !== 0) begin errors++; $display("FAIL stop_pixels: got %0d left=%0d, want 24 / 0", accepted, sb.size()); end
  endtask

  task automatic test_reset_mid();
    begin_run(8'd1, 1, 1'b0);
    for (int k = 1; k <= 11; k++) begin
      drive(k == 10, 1'b0, 1'b0, 1'b1, 1'b1);
      sample(k);
    end
    vectors++; if ({busy, pat_enable, done} !== 3'b000) begin errors++; $display("FAIL rst_mid_flags: got busy/en/done=%b, want 000", {busy, pat_enable, done}); end
    vectors++; if ({pat_vcnt, pat_hcnt} !== 19'd0) begin errors++; $display("FAIL rst_mid_counters: got v=%0d h=%0d, want 0 0", pat_vcnt, pat_hcnt); end
    vectors++; if (done_cnt !== 0) begin errors++; $display("FAIL rst_mid_no_done: got %0d, want 0", done_cnt); end
    sb.delete();
    begin_run(8'd1, 1, 1'b0);
    for (int k = 1; k <= 80; k++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      sample(k);
      if (done_k >= 0 && k > done_k) break;
    end
    vectors++; if (first_en !== 2 || en_cnt !== 32) begin errors++; $display("FAIL rst_mid_restart: got first %0d count %0d, want 2 / 32", first_en, en_cnt); end
    vectors++; if (done_k !== 34 || sb.size() !== 0) begin errors++; $display("FAIL rst_mid_complete: got done %0d left=%0d, want 34 / 0", done_k, sb.size()); end
  endtask

  initial begin
    vectors = 0; errors = 0; accepted = 0; sr_seen = 1'b0;
    rst = 1'b1; start = 1'b0; stop = 1'b0; in_frames = 8'd0;
    src_valid = 1'b0; src_pixel = 8'd0; dst_ready = 1'b0; px_next = 8'd5;
    test_reset();
    test_basic();
    test_src_stall();
    test_blank_invalid();
    test_dst_stall();
    test_stop();
    test_reset_mid();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
